// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int ADDR_W  = 64;
    localparam int INST_W  = 32;
    localparam int PC_STEP = 4;

    typedef enum logic [1:0] {
        LOAD,
        IDLE,
        REQ,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Sequential successor of a fetch address; wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(PC_STEP);
    endfunction

endpackage

// File: rtl/fetch_prefetch_unit_fifo.sv
// Prefetch FIFO holding {pc, inst} entries; head is a register so the
// output word and PC appear with the same timing as the count.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output fetch_entry_t     head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     r_mem [DEPTH];
    fetch_entry_t     r_head;
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W-1:0] r_wr;
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] w_rd_nxt;
    logic [CNT_W-1:0] w_cnt_after_pop;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_pop;
    logic             w_push;

    assign w_pop           = pop && (r_count != '0);
    assign w_push          = push && ((r_count != CNT_W'(DEPTH)) || w_pop);
    assign w_rd_nxt        = r_rd + PTR_W'(w_pop);
    assign w_cnt_after_pop = r_count - CNT_W'(w_pop);
    assign w_cnt_nxt       = w_cnt_after_pop + CNT_W'(w_push);

    // Storage array: write the pushed entry at the tail slot.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the queue outright.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            r_rd    <= w_rd_nxt;
            r_wr    <= r_wr + PTR_W'(w_push);
            r_count <= w_cnt_nxt;
        end
    end

    // Head register: follows the next head, bypassing a push into an empty
    // queue, and keeps its last value whenever the queue goes empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
        end else if (!flush && (w_cnt_nxt != '0)) begin
            r_head <= (w_cnt_after_pop == '0) ? push_data : r_mem[w_rd_nxt];
        end
    end

    assign count = r_count;
    assign head  = r_head;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch front end: sequential PC generation, single-outstanding memory
// request handshake, prefetch buffering and redirect/flush handling.
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [ADDR_W-1:0] startpc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] instruction,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic              r_req;
    logic              w_req_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] w_fetch_pc_nxt;
    logic [CNT_W-1:0]  w_count;
    fetch_entry_t      w_head;
    fetch_entry_t      w_push_entry;
    logic              w_valid;
    logic              w_flush;
    logic              w_push;
    logic              w_pop;
    logic              w_room_idle;
    logic              w_room_ack;

    // Redirect beats an ack push, which beats a pop; LOAD ignores redirect.
    assign w_valid      = (w_count != '0);
    assign w_flush      = redirect && (r_state != LOAD);
    assign w_push       = (r_state == REQ) && imem_ack && !w_flush;
    assign w_pop        = inst_ready && w_valid && !w_flush;
    assign w_push_entry = {r_fetch_pc, imem_data};

    // A new request only goes out if its eventual ack is guaranteed a slot.
    assign w_room_idle  = (w_count - CNT_W'(w_pop)) < CNT_W'(DEPTH);
    assign w_room_ack   = (w_count + CNT_W'(1) - CNT_W'(w_pop)) < CNT_W'(DEPTH);

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (reset),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .flush     (w_flush),
        .count     (w_count),
        .head      (w_head)
    );

    // FSM state register.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, request and fetch-PC decisions.
    always_comb begin
        w_state_nxt    = r_state;
        w_req_nxt      = r_req;
        w_addr_nxt     = r_addr;
        w_fetch_pc_nxt = r_fetch_pc;
        case (r_state)
            LOAD: begin
                w_fetch_pc_nxt = startpc;
                w_state_nxt    = IDLE;
            end
            IDLE: begin
                if (redirect) begin
                    w_fetch_pc_nxt = redirect_pc;
                end else if (w_room_idle) begin
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = r_fetch_pc;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    w_fetch_pc_nxt = redirect_pc;
                    if (imem_ack) begin
                        w_req_nxt   = 1'b0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = DRAIN;
                    end
                end else if (imem_ack) begin
                    w_fetch_pc_nxt = next_pc(r_fetch_pc);
                    if (w_room_ack) begin
                        w_addr_nxt = next_pc(r_fetch_pc);
                    end else begin
                        w_req_nxt   = 1'b0;
                        w_state_nxt = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (redirect) begin
                    w_fetch_pc_nxt = redirect_pc;
                end
                if (imem_ack) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = LOAD;
            end
        endcase
    end

    // Request and fetch-PC registers; reset drops imem_req immediately.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_req      <= 1'b0;
            r_addr     <= '0;
            r_fetch_pc <= '0;
        end else begin
            r_req      <= w_req_nxt;
            r_addr     <= w_addr_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign inst_valid  = w_valid;
    assign instruction = w_head.inst;
    assign inst_pc     = w_head.pc;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Scoreboard bench for fetch_prefetch_unit with a behavioural memory/core model.
module tb_fetch_prefetch_unit;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic        CLK;
    logic        reset;
    logic [63:0] startpc;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [63:0] inst_pc;

    fetch_prefetch_unit #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .reset(reset), .startpc(startpc), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .instruction(instruction), .inst_pc(inst_pc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    // Reference state: words the core should still see, in order.
    fetch_entry_t sb[$];
    logic [63:0]  model_pc;
    bit           push_now, flush_now, mon_en;
    logic [63:0]  last_pc;
    logic [31:0]  last_inst;

    // Memory-side model state.
    bit          drv_busy, drv_stale;
    int          drv_wait, cyc;
    logic [63:0] drv_addr;

    // Knobs and statistics.
    int          lat_min, lat_max, ready_pct, redir_pct;
    bit          dir_armed, dir_on_ack, dir_any;
    logic [63:0] dir_addr, dir_target;
    int          acks_live, pops;
    bit          saw_zero, first_chk;
    logic [63:0] first_exp;

    function automatic logic [31:0] memword(input logic [63:0] a);
        return a[31:0] ^ {a[47:32], a[63:48]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Memory responder and core-side redirect/ready driver.
    initial begin
        bit do_ack, do_redir;
        forever begin
            @(posedge CLK);
            #1;
            imem_ack  = 1'b0;
            redirect  = 1'b0;
            push_now  = 1'b0;
            flush_now = 1'b0;
            if (reset) begin
                drv_busy  = 1'b0;
                drv_stale = 1'b0;
                cyc       = 0;
                continue;
            end
            cyc++;
            do_ack   = 1'b0;
            do_redir = 1'b0;
            inst_ready = ($urandom_range(99) < ready_pct);
            if (drv_busy) begin
                check(imem_req == 1'b1, "req_held", imem_req, 1);
                check(imem_addr == drv_addr, "req_addr_stable", imem_addr, drv_addr);
            end else if (imem_req) begin
                drv_busy  = 1'b1;
                drv_stale = 1'b0;
                drv_addr  = imem_addr;
                drv_wait  = $urandom_range(lat_max, lat_min);
                check(imem_addr == model_pc, "req_addr", imem_addr, model_pc);
                if (imem_addr == 64'h0) saw_zero = 1'b1;
            end
            if (drv_busy) begin
                if (drv_wait == 0) do_ack = 1'b1;
                else drv_wait--;
            end
            if (cyc >= 2) begin
                if (dir_armed && drv_busy && (dir_any || drv_addr == dir_addr) && (do_ack == dir_on_ack)) begin
                    do_redir    = 1'b1;
                    dir_armed   = 1'b0;
                    first_chk   = 1'b1;
                    first_exp   = dir_target;
                    redirect_pc = dir_target;
                    if (dir_on_ack) inst_ready = 1'b1;
                end else if (redir_pct > 0 && $urandom_range(99) < redir_pct) begin
                    do_redir    = 1'b1;
                    first_chk   = 1'b0;
                    redirect_pc = {$urandom, $urandom} & ~64'h3;
                end
            end
            if (do_ack) begin
                imem_ack = 1'b1;
                if (drv_stale || do_redir) begin
                    imem_data = memword(drv_addr) ^ 32'hFFFF_0000;
                end else begin
                    imem_data = memword(drv_addr);
                    sb.push_back(fetch_entry_t'{pc: drv_addr, inst: imem_data});
                    push_now = 1'b1;
                    model_pc = drv_addr + 64'd4;
                    acks_live++;
                    check(sb.size() <= DEPTH, "no_overflow", sb.size(), DEPTH);
                end
                drv_busy  = 1'b0;
                drv_stale = 1'b0;
            end
            if (do_redir) begin
                redirect  = 1'b1;
                flush_now = 1'b1;
                model_pc  = redirect_pc;
                if (drv_busy) drv_stale = 1'b1;
            end
        end
    end

    // Monitor: compares the presented head against the scoreboard each cycle.
    initial begin
        int exp_cnt;
        forever begin
            @(negedge CLK);
            if (!mon_en) continue;
            exp_cnt = sb.size() - int'(push_now);
            check(inst_valid == (exp_cnt != 0), "inst_valid", inst_valid, exp_cnt != 0);
            if (exp_cnt != 0) begin
                check(inst_pc == sb[0].pc, "inst_pc", inst_pc, sb[0].pc);
                check(instruction == sb[0].inst, "instruction", instruction, sb[0].inst);
                last_pc   = sb[0].pc;
                last_inst = sb[0].inst;
            end else begin
                check(inst_pc == last_pc, "hold_pc", inst_pc, last_pc);
                check(instruction == last_inst, "hold_inst", instruction, last_inst);
            end
            if (exp_cnt == DEPTH) check(imem_req == 1'b0, "req_while_full", imem_req, 0);
            if (flush_now) begin
                sb.delete();
            end else if (exp_cnt != 0 && inst_ready) begin
                if (first_chk) begin
                    check(sb[0].pc == first_exp && inst_pc == first_exp, "redir_first_pc", inst_pc, first_exp);
                    first_chk = 1'b0;
                end
                void'(sb.pop_front());
                pops++;
            end
        end
    end

    task automatic do_reset(input logic [63:0] spc);
        mon_en  = 1'b0;
        reset   = 1'b1;
        startpc = spc;
        repeat (3) @(posedge CLK);
        #1;
        check(imem_req == 1'b0, "rst_req", imem_req, 0);
        check(imem_addr == 64'h0, "rst_addr", imem_addr, 0);
        check(inst_valid == 1'b0, "rst_valid", inst_valid, 0);
        check(inst_pc == 64'h0, "rst_pc", inst_pc, 0);
        check(instruction == 32'h0, "rst_inst", instruction, 0);
        sb.delete();
        model_pc  = spc;
        last_pc   = 64'h0;
        last_inst = 32'h0;
        first_chk = 1'b0;
        dir_armed = 1'b0;
        @(negedge CLK);
        reset  = 1'b0;
        mon_en = 1'b1;
    endtask

    initial begin
        redirect = 0; redirect_pc = 0; imem_ack = 0; imem_data = 0; inst_ready = 0;
        lat_min = 0; lat_max = 0; ready_pct = 100; redir_pct = 0;
        dir_armed = 0; dir_on_ack = 0; dir_any = 0; dir_addr = 0; dir_target = 0;
        acks_live = 0; pops = 0; saw_zero = 0; mon_en = 0;

        // Streaming with immediate acks.
        do_reset(64'h1000);
        pops = 0;
        repeat (40) @(posedge CLK);
        check(pops >= 30, "stream_rate", pops, 30);

        // Core stalled: buffer fills to exactly DEPTH, then drains in order.
        ready_pct = 0;
        do_reset(64'h1000);
        acks_live = 0;
        repeat (20) @(posedge CLK);
        check(acks_live == DEPTH, "fill_acks", acks_live, DEPTH);
        check(sb.size() == DEPTH, "fill_level", sb.size(), DEPTH);
        ready_pct = 100;
        pops = 0;
        repeat (12) @(posedge CLK);
        check(pops >= DEPTH, "drain_pops", pops, DEPTH);

        // Redirect while 0x1008 is outstanding with slow memory.
        lat_min = 3; lat_max = 3;
        do_reset(64'h1000);
        dir_addr = 64'h1008; dir_target = 64'h2000; dir_on_ack = 0; dir_any = 0; dir_armed = 1;
        repeat (40) @(posedge CLK);
        check(dir_armed == 1'b0, "drain_redir_fired", dir_armed, 0);
        check(first_chk == 1'b0, "drain_redir_seen", first_chk, 0);

        // Redirect coinciding with ack and ready.
        lat_min = 0; lat_max = 0;
        dir_target = 64'h3000; dir_on_ack = 1; dir_any = 1; dir_armed = 1;
        repeat (20) @(posedge CLK);
        check(dir_armed == 1'b0, "ack_redir_fired", dir_armed, 0);
        check(first_chk == 1'b0, "ack_redir_seen", first_chk, 0);

        // Address wrap-around past the top of the address space.
        saw_zero = 0;
        dir_target = 64'hFFFF_FFFF_FFFF_FFF8; dir_on_ack = 1; dir_any = 1; dir_armed = 1;
        repeat (20) @(posedge CLK);
        check(saw_zero == 1'b1, "wrap_to_zero", saw_zero, 1);

        // Randomized latency, backpressure and redirects.
        lat_min = 0; lat_max = 3; ready_pct = 75; redir_pct = 6;
        repeat (3000) @(posedge CLK);

        // Reset asserted while a request is outstanding.
        redir_pct = 0; ready_pct = 100; lat_min = 3; lat_max = 3;
        begin
            bit seen = 0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(negedge CLK);
                seen = imem_req;
            end
            check(seen, "req_before_reset", seen, 1);
        end
        mon_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        check(imem_req == 1'b0, "async_rst_req", imem_req, 0);
        check(inst_valid == 1'b0, "async_rst_valid", inst_valid, 0);
        do_reset(64'h4000);
        pops = 0;
        repeat (40) @(posedge CLK);
        check(pops > 0, "post_reset_fetch", pops, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the single-cycle datapath.
- Generates sequential fetch addresses and requests words from a variable-latency instruction memory over a req/ack handshake.
- Buffers fetched words with their PCs in a small prefetch FIFO and presents them to the core over a valid/ready handshake.
- A taken branch or jump from the core's next-PC logic arrives as a redirect; it flushes the FIFO and restarts fetch at the target.

Parameters:
- DEPTH, 4: prefetch FIFO entries (power of 2, minimum 2).
- ADDR_W, 64: PC / address width.
- INST_W, 32: instruction width.
- PC_STEP, 4: byte increment between sequential fetches.

Ports:
- CLK  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- startpc  in  ADDR_W  first fetch address after reset
- redirect  in  1  core requests fetch restart (taken branch or unconditional branch)
- redirect_pc  in  ADDR_W  restart target, sampled when redirect=1
- imem_req  out  1  memory request valid
- imem_addr  out  ADDR_W  request address
- imem_ack  in  1  one-cycle pulse: request complete, imem_data valid
- imem_data  in  INST_W  fetched word
- inst_valid  out  1  FIFO head valid
- inst_ready  in  1  core consumes head
- instruction  out  INST_W  FIFO head word
- inst_pc  out  ADDR_W  PC of the FIFO head word

Behaviour:
- Clock and reset: one clock domain, CLK. Reset is asynchronous, active-high, and is released synchronously by the environment.
- Reset values: state=LOAD, FIFO empty, count=0, imem_req=0, imem_addr=0, inst_valid=0, instruction=0, inst_pc=0, fetch_pc=0.
- FSM states: LOAD, IDLE, REQ, DRAIN.
- LOAD: on the first clock after reset deasserts, fetch_pc<=startpc, then go to IDLE.
- IDLE: if count<DEPTH and redirect=0, assert imem_req with imem_addr=fetch_pc; go to REQ on the next edge.
- REQ:
  - imem_req and imem_addr are held stable until imem_ack.
  - On ack: push {fetch_pc, imem_data}; fetch_pc<=fetch_pc+PC_STEP (modulo 2^ADDR_W, no overflow flag).
  - Then issue the next request back-to-back if space remains, otherwise go to IDLE.
- Space rule: at most one outstanding request. A new request is issued only if (count + 1 after any same-cycle pop) leaves room, so an ack never finds the FIFO full.
- Redirect (any state except LOAD):
  - FIFO flushed (count<=0, inst_valid=0 next cycle).
  - fetch_pc<=redirect_pc.
  - If a request is outstanding with no ack this cycle, go to DRAIN.
  - If redirect and ack occur in the same cycle, the acked data is discarded and the FSM goes to IDLE.
- DRAIN: imem_req stays high, address unchanged, until imem_ack. The returned data is discarded, then go to IDLE. A further redirect while in DRAIN only updates fetch_pc.
- Priority: redirect > ack push > pop. Redirect and pop in the same cycle: the pop is ignored, flush wins.
- Simultaneous push and pop when count=DEPTH-1: legal, count unchanged.
- Output path: inst_valid=(count!=0). instruction and inst_pc are driven from the head register with zero latency relative to inst_valid. When inst_valid=0, both hold their last value.
- Fetch latency: the first word is visible at inst_valid no earlier than 1 cycle after imem_ack.
- Reset mid-request: all state is cleared immediately and imem_req drops asynchronously. The memory is required to abandon the transaction.

Decomposition:
- Shared package fetch_pkg holds:
  - fetch_state_t enum (LOAD, IDLE, REQ, DRAIN).
  - Constants INST_W, ADDR_W, PC_STEP.
  - A packed fetch_entry_t {pc, inst}.
- Sub-module fetch_fifo: parameterised DEPTH synchronous FIFO with push, pop, flush, count, head outputs, and async active-high reset.
- The FSM and the PC incrementer live in fetch_prefetch_unit.

Test Plan:
- Fixed 1-cycle ack latency, startpc=0x1000, inst_ready=1 → inst_pc sequence 0x1000, 0x1004, 0x1008… with no gaps after fill; imem_addr increments by 4.
- inst_ready=0 with DEPTH=4 → exactly 4 acks accepted, imem_req=0 while full, no FIFO overflow; setting inst_ready=1 drains the 4 entries in order and fetching resumes at 0x1010.
- Redirect to 0x2000 while a request for 0x1008 is outstanding with 3-cycle ack latency → DRAIN; the 0x1008 data is never presented; the next inst_pc is 0x2000.
- Redirect to 0x3000 in the same cycle as imem_ack and inst_ready → FIFO empty next cycle, acked word dropped, next request address 0x3000.
- fetch_pc=0xFFFF_FFFF_FFFF_FFFC → the following request address is 0x0 (wrap-around).
- Assert reset while imem_req=1 → imem_req=0 and inst_valid=0 immediately; after release, the first request address equals startpc (0x4000).
